ila_window_capture: RTL

- Single-clock successor to the ILA sampling core: a capture engine with programmable pre-trigger and post-trigger windows, sample decimation and per-bit edge or level triggers.
- Samples live in a circular buffer; the block reports the trigger address and the window start address.
- Software reads the buffer DATA_W bits at a time through an indexed read port with a valid strobe.
- Sits between the probed signals and the ILA register bank, replacing the free-running capture path.

---
 rtl/ila_window_pkg.sv | 26 ++
 rtl/ila_window_trigger.sv | 33 +++
 rtl/iob_ram_t2p.sv | 24 ++
 rtl/ila_window_capture.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ila_window_pkg.sv
// Shared types and width helpers for the windowed ILA capture engine.
package ila_window_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic RED_OR  = 1'b0;
   localparam logic RED_AND = 1'b1;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Slice-select width for reading a wide sample through a narrower port.
   function automatic int sel_w(input int sig_w, input int dat_w);
      int n;
      n = ceil_div(sig_w, dat_w);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ila_window_trigger.sv
// Per-bit negate / edge / mask trigger qualification with OR or AND reduction.
module ila_window_trigger
   import ila_window_pkg::*;
#(
   parameter int TRIGGER_W = 4
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic                 s_en_i,
   input  logic [TRIGGER_W-1:0] trigger_i,
   input  logic [TRIGGER_W-1:0] trig_mask_i,
   input  logic [TRIGGER_W-1:0] trig_negate_i,
   input  logic [TRIGGER_W-1:0] trig_edge_i,
   input  logic                 trig_and_i,
   output logic                 hit_o
);

   logic [TRIGGER_W-1:0] r_prev;
   logic [TRIGGER_W-1:0] w_t;
   logic [TRIGGER_W-1:0] w_bit;

   assign w_t   = trigger_i ^ trig_negate_i;
   assign w_bit = w_t & ~(trig_edge_i & r_prev);

   // History only advances on sample strobes so edges are seen in the decimated domain.
   always_ff @(posedge clk_i or negedge arst_n_i)
      if (!arst_n_i)   r_prev <= '0;
      else if (s_en_i) r_prev <= w_t;

   assign hit_o = (trig_and_i == RED_AND) ? ((&(w_bit | ~trig_mask_i)) & (|trig_mask_i))
                                          : (|(w_bit & trig_mask_i));

endmodule

// File: rtl/iob_ram_t2p.sv
// Two-port RAM: one write port, one registered read port (old data on collision).
module iob_ram_t2p #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              w_clk_i,
   input  logic              w_en_i,
   input  logic [ADDR_W-1:0] w_addr_i,
   input  logic [DATA_W-1:0] w_data_i,
   input  logic              r_clk_i,
   input  logic              r_en_i,
   input  logic [ADDR_W-1:0] r_addr_i,
   output logic [DATA_W-1:0] r_data_o
);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

   always_ff @(posedge w_clk_i)
      if (w_en_i) r_mem[w_addr_i] <= w_data_i;

   always_ff @(posedge r_clk_i)
      if (r_en_i) r_data_o <= r_mem[r_addr_i];

endmodule

// File: rtl/ila_window_capture.sv
// Capture engine: pre/post trigger windows into a circular buffer, decimated sampling,
// indexed DATA_W-wide read-back of SIGNAL_W-wide samples.
module ila_window_capture
   import ila_window_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int SIGNAL_W  = 48,
   parameter int BUFFER_W  = 8,
   parameter int TRIGGER_W = 4,
   parameter int DECIM_W   = 8,
   parameter int SEL_W     = sel_w(SIGNAL_W, DATA_W)
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic                 cke_i,
   input  logic [SIGNAL_W-1:0]  signal_i,
   input  logic [TRIGGER_W-1:0] trigger_i,
   input  logic [TRIGGER_W-1:0] trig_mask_i,
   input  logic [TRIGGER_W-1:0] trig_negate_i,
   input  logic [TRIGGER_W-1:0] trig_edge_i,
   input  logic                 trig_and_i,
   input  logic [BUFFER_W-1:0]  pre_samples_i,
   input  logic [BUFFER_W-1:0]  post_samples_i,
   input  logic [DECIM_W-1:0]   decim_i,
   input  logic                 arm_i,
   input  logic                 abort_i,
   output logic [2:0]           state_o,
   output logic                 triggered_o,
   output logic                 done_o,
   output logic [BUFFER_W-1:0]  trig_addr_o,
   output logic [BUFFER_W-1:0]  start_addr_o,
   input  logic                 rd_en_i,
   input  logic [BUFFER_W-1:0]  rd_addr_i,
   input  logic [SEL_W-1:0]     rd_sel_i,
   output logic [DATA_W-1:0]    rd_data_o,
   output logic                 rd_valid_o
);

   localparam int NSL   = ceil_div(SIGNAL_W, DATA_W);
   localparam int PAD_W = NSL * DATA_W;

   state_t              r_state, w_next;
   logic [BUFFER_W-1:0] r_wr_ptr, r_cnt, r_pre, r_post, r_trig_addr, r_start_addr;
   logic [BUFFER_W-1:0] w_room, w_post_lim;
   logic [DECIM_W-1:0]  r_decim, r_dcnt;
   logic                r_triggered, r_done;
   logic                w_s_en, w_hit, w_we, w_capture, w_arm;

   assign w_s_en     = cke_i & (r_dcnt == '0);
   assign w_arm      = arm_i & ~abort_i;
   // DEPTH-1-pre is the bitwise complement of pre, so it cannot underflow.
   assign w_room     = ~pre_samples_i;
   assign w_post_lim = (post_samples_i < w_room) ? post_samples_i : w_room;

   ila_window_trigger #(.TRIGGER_W(TRIGGER_W)) u_trig (
      .clk_i         (clk_i),
      .arst_n_i      (arst_n_i),
      .s_en_i        (w_s_en),
      .trigger_i     (trigger_i),
      .trig_mask_i   (trig_mask_i),
      .trig_negate_i (trig_negate_i),
      .trig_edge_i   (trig_edge_i),
      .trig_and_i    (trig_and_i),
      .hit_o         (w_hit)
   );

   always_ff @(posedge clk_i or negedge arst_n_i)
      if (!arst_n_i)  r_state <= ST_IDLE;
      else if (cke_i) r_state <= w_next;

   always_comb begin
      w_next = r_state;
      if (abort_i)     w_next = ST_IDLE;
      else if (arm_i)  w_next = (pre_samples_i == '0) ? ST_WAIT : ST_PRE;
      else if (w_s_en) begin
         case (r_state)
            ST_PRE:  if (r_cnt == r_pre - BUFFER_W'(1)) w_next = ST_WAIT;
            ST_WAIT: if (w_hit) w_next = (r_post == '0) ? ST_DONE : ST_POST;
            ST_POST: if (r_cnt == r_post - BUFFER_W'(1)) w_next = ST_DONE;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_we      = 1'b0;
      w_capture = 1'b0;
      if (w_s_en && !abort_i && !arm_i) begin
         case (r_state)
            ST_PRE, ST_POST: w_we = 1'b1;
            ST_WAIT: begin
               w_we      = 1'b1;
               w_capture = w_hit;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i)
      if (!arst_n_i) begin
         r_wr_ptr     <= '0;
         r_cnt        <= '0;
         r_pre        <= '0;
         r_post       <= '0;
         r_decim      <= '0;
         r_dcnt       <= '0;
         r_trig_addr  <= '0;
         r_start_addr <= '0;
         r_triggered  <= 1'b0;
         r_done       <= 1'b0;
      end else if (cke_i) begin
         r_dcnt <= w_arm ? '0 : (w_s_en ? r_decim : r_dcnt - DECIM_W'(1));
         if (abort_i) begin
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
         end else if (arm_i) begin
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_pre       <= pre_samples_i;
            r_post      <= w_post_lim;
            r_decim     <= decim_i;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
         end else begin
            if (w_we) begin
               r_wr_ptr <= r_wr_ptr + BUFFER_W'(1);
               r_cnt    <= (w_next != r_state) ? '0 : r_cnt + BUFFER_W'(1);
            end
            if (w_capture) begin
               r_trig_addr  <= r_wr_ptr;
               r_start_addr <= r_wr_ptr - r_pre;
               r_triggered  <= 1'b1;
            end
            if (w_next == ST_DONE && r_state != ST_DONE) r_done <= 1'b1;
         end
      end

   assign state_o      = r_state;
   assign triggered_o  = r_triggered;
   assign done_o       = r_done;
   assign trig_addr_o  = r_trig_addr;
   assign start_addr_o = r_start_addr;

   logic [SEL_W-1:0]    r_sel;
   logic                r_rd_valid, r_rd_any;
   logic [SIGNAL_W-1:0] w_ram_q;
   logic [PAD_W-1:0]    w_pad;

   iob_ram_t2p #(.DATA_W(SIGNAL_W), .ADDR_W(BUFFER_W)) u_ram (
      .w_clk_i  (clk_i),
      .w_en_i   (w_we),
      .w_addr_i (r_wr_ptr),
      .w_data_i (signal_i),
      .r_clk_i  (clk_i),
      .r_en_i   (rd_en_i & cke_i),
      .r_addr_i (rd_addr_i),
      .r_data_o (w_ram_q)
   );

   always_ff @(posedge clk_i or negedge arst_n_i)
      if (!arst_n_i) begin
         r_sel      <= '0;
         r_rd_valid <= 1'b0;
         r_rd_any   <= 1'b0;
      end else if (cke_i) begin
         r_rd_valid <= rd_en_i;
         if (rd_en_i) begin
            r_sel    <= rd_sel_i;
            r_rd_any <= 1'b1;
         end
      end

   assign w_pad = PAD_W'(w_ram_q);

   // RAM output is unreset; mask it until the first read lands.
   always_comb begin
      rd_data_o = '0;
      if (r_rd_any)
         for (int i = 0; i < NSL; i++)
            if (int'(r_sel) == i) rd_data_o = w_pad[i*DATA_W +: DATA_W];
   end

   assign rd_valid_o = r_rd_valid;

endmodule
